// File: rtl/onehot_to_binary_pkg.sv
// Widths shared by the one-hot to binary decoder
// and by every block that consumes its outputs.
package onehot_to_binary_pkg;
   localparam int STATE_W = 8;
   localparam int BIN_W   = $clog2(STATE_W);
endpackage

// File: rtl/rr_grant_arbiter_pkg.sv
// Types, widths and the rotating-priority pick
// used by the round-robin grant arbiter.
package rr_grant_arbiter_pkg;
   import onehot_to_binary_pkg::*;

   localparam int REQ_W = STATE_W;
   localparam int IDX_W = BIN_W;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

   // One-hot winner: search from ptr+1, wrap, end at ptr.
   function automatic logic [REQ_W-1:0] rr_pick(
      input logic [REQ_W-1:0] req,
      input logic [IDX_W-1:0] ptr
   );
      logic [REQ_W-1:0] g;
      logic             found;
      int               j;
      g     = '0;
      found = 1'b0;
      for (int k = 1; k <= REQ_W; k++) begin
         j = (int'(ptr) + k) % REQ_W;
         if (!found && req[j[IDX_W-1:0]]) begin
            g[j[IDX_W-1:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters
// (master) and the arbiter (slave).
interface rr_grant_arbiter_if;
   import rr_grant_arbiter_pkg::*;

   logic [REQ_W-1:0] req_i;
   logic             done_i;
   logic [REQ_W-1:0] grant_o;
   logic [IDX_W-1:0] grant_idx_o;
   logic             grant_valid_o;
   logic             timeout_o;

   modport slave (
      input  req_i, done_i,
      output grant_o, grant_idx_o,
      output grant_valid_o, timeout_o
   );

   modport master (
      output req_i, done_i,
      input  grant_o, grant_idx_o,
      input  grant_valid_o, timeout_o
   );
endinterface

// File: rtl/rr_grant_arbiter_onehot_to_binary.sv
// One-hot to binary index decoder; valid_o is
// high only when exactly one input bit is set.
module onehot_to_binary
   import onehot_to_binary_pkg::*;
(
   input  logic [STATE_W-1:0] onehot_i,
   output logic [BIN_W-1:0]   bin_o,
   output logic               valid_o
);
   // OR together the indices of set bits; 0 when idle.
   always_comb begin
      bin_o = '0;
      for (int k = 0; k < STATE_W; k++) begin
         if (onehot_i[k]) begin
            bin_o = bin_o | BIN_W'(k);
         end
      end
      valid_o = (onehot_i != '0) &&
                ((onehot_i & (onehot_i - 1'b1)) == '0);
   end
endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant,
// held until done, request drop or hold timeout.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N_REQ    = 8,
   parameter int MAX_HOLD = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   rr_grant_arbiter_if.slave  bus
);
   localparam int CNT_W =
      (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   if (N_REQ != REQ_W) begin : g_bad_n
      $error("N_REQ must equal decoder STATE_W");
   end

   arb_state_t       state_q;
   logic [REQ_W-1:0] grant_q;
   logic [IDX_W-1:0] ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   logic [IDX_W-1:0] idx;
   logic             vld;
   logic             rel_usr_d;
   logic             rel_tmo_d;
   logic [REQ_W-1:0] grant_d;

   onehot_to_binary u_dec (
      .onehot_i (grant_q),
      .bin_o    (idx),
      .valid_o  (vld)
   );

   // Release causes and the next winner, current winner masked.
   always_comb begin
      rel_usr_d = bus.done_i | ~|(bus.req_i & grant_q);
      rel_tmo_d = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
      if (state_q == ST_BUSY) begin
         grant_d = rr_pick(bus.req_i & ~grant_q, idx);
      end else begin
         grant_d = rr_pick(bus.req_i, ptr_q);
      end
   end

   // Grant FSM with hold counter and timeout pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ptr_q     <= IDX_W'(N_REQ - 1);
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               timeout_q <= 1'b0;
               cnt_q     <= '0;
               if (|bus.req_i) begin
                  grant_q <= grant_d;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (rel_usr_d || rel_tmo_d) begin
                  ptr_q     <= idx;
                  cnt_q     <= '0;
                  timeout_q <= rel_tmo_d & ~rel_usr_d;
                  grant_q   <= grant_d;
                  if (grant_d == '0) begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  timeout_q <= 1'b0;
                  if (cnt_q != {CNT_W{1'b1}}) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   // A registered grant is one-hot exactly while busy.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         a_valid_busy: assert (vld == (state_q == ST_BUSY));
      end
   end

   assign bus.grant_o       = grant_q;
   assign bus.grant_idx_o   = idx;
   assign bus.grant_valid_o = vld;
   assign bus.timeout_o     = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with a
// per-cycle reference model (MAX_HOLD 4 and 0).
module tb_rr_grant_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   rr_grant_arbiter_if ifa ();
   rr_grant_arbiter_if ifb ();

   assign ifa.req_i  = req;
   assign ifa.done_i = done;
   assign ifb.req_i  = req;
   assign ifb.done_i = done;

   rr_grant_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifa.slave)
   );

   rr_grant_arbiter #(.N_REQ(8), .MAX_HOLD(0)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifb.slave)
   );

   // Reference model: who holds the resource, and for how long.
   bit m_busy [2];
   int m_win  [2];
   int m_ptr  [2];
   int m_cnt  [2];
   bit m_tmo  [2];

   function automatic int search(input logic [7:0] r, input int p);
      for (int k = 1; k <= 8; k++) begin
         int j;
         j = (p + k) % 8;
         if (r[j[2:0]]) return j;
      end
      return -1;
   endfunction

   task automatic step(input int i, input int mh);
      int  w;
      bit  a, b, c;
      if (rst) begin
         m_busy[i] = 0; m_win[i] = 0; m_ptr[i] = 7;
         m_cnt[i]  = 0; m_tmo[i] = 0;
      end else if (!m_busy[i]) begin
         m_tmo[i] = 0;
         w = search(req, m_ptr[i]);
         if (w >= 0) begin
            m_busy[i] = 1; m_win[i] = w; m_cnt[i] = 0;
         end
      end else begin
         a = done;
         b = !req[m_win[i]];
         c = (mh != 0) && (m_cnt[i] == mh - 1);
         if (a || b || c) begin
            m_tmo[i] = c && !a && !b;
            m_ptr[i] = m_win[i];
            m_cnt[i] = 0;
            w = search(req & ~(8'd1 << m_win[i]), m_ptr[i]);
            if (w >= 0) m_win[i] = w;
            else        m_busy[i] = 0;
         end else begin
            m_tmo[i] = 0;
            m_cnt[i]++;
         end
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model advances on each edge; outputs compared mid-cycle.
   initial begin
      forever begin
         @(posedge clk);
         step(0, 4);
         step(1, 0);
         @(negedge clk);
         chk("a_grant", int'(ifa.grant_o),
             m_busy[0] ? (1 << m_win[0]) : 0);
         chk("a_idx", int'(ifa.grant_idx_o),
             m_busy[0] ? m_win[0] : 0);
         chk("a_valid", int'(ifa.grant_valid_o), int'(m_busy[0]));
         chk("a_tmo", int'(ifa.timeout_o), int'(m_tmo[0]));
         chk("b_grant", int'(ifb.grant_o),
             m_busy[1] ? (1 << m_win[1]) : 0);
         chk("b_idx", int'(ifb.grant_idx_o),
             m_busy[1] ? m_win[1] : 0);
         chk("b_valid", int'(ifb.grant_valid_o), int'(m_busy[1]));
         chk("b_tmo", int'(ifb.timeout_o), int'(m_tmo[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

   // Directed scenarios with literal expectations on dut_a.
   initial begin
      rst = 1'b1; req = 8'h00; done = 1'b0;
      cyc(2);
      rst = 1'b0;

      for (int n = 0; n < 10; n++) begin
         cyc(1);
         chk("t1_grant", int'(ifa.grant_o), 0);
         chk("t1_idx", int'(ifa.grant_idx_o), 0);
         chk("t1_valid", int'(ifa.grant_valid_o), 0);
         chk("t1_tmo", int'(ifa.timeout_o), 0);
      end

      req = 8'h81;
      cyc(1);
      chk("t2_first", int'(ifa.grant_o), 'h01);
      chk("t2_first_idx", int'(ifa.grant_idx_o), 0);
      done = 1'b1;
      cyc(1);
      done = 1'b0;
      chk("t2_b2b", int'(ifa.grant_o), 'h80);
      chk("t2_b2b_idx", int'(ifa.grant_idx_o), 7);
      chk("t2_b2b_valid", int'(ifa.grant_valid_o), 1);
      req = 8'h00;
      cyc(1);
      chk("t2_idle", int'(ifa.grant_o), 0);

      req = 8'hFF;
      cyc(1);
      for (int k = 0; k < 10; k++) begin
         chk("t3_idx_b", int'(ifb.grant_idx_o), seq[k]);
         chk("t3_valid_b", int'(ifb.grant_valid_o), 1);
         cyc(1);
         chk("t3_hold_b", int'(ifb.grant_idx_o), seq[k]);
         done = 1'b1;
         cyc(1);
         done = 1'b0;
      end
      req = 8'h00;
      cyc(1);

      req = 8'h04;
      for (int n = 0; n < 4; n++) begin
         cyc(1);
         chk("t4_hold", int'(ifa.grant_o), 'h04);
         chk("t4_no_tmo", int'(ifa.timeout_o), 0);
      end
      cyc(1);
      chk("t4_gap", int'(ifa.grant_o), 0);
      chk("t4_tmo", int'(ifa.timeout_o), 1);
      chk("t4_b_no_tmo", int'(ifb.grant_o), 'h04);
      cyc(1);
      chk("t4_regrant", int'(ifa.grant_o), 'h04);
      chk("t4_tmo_clr", int'(ifa.timeout_o), 0);
      req = 8'h00;
      cyc(1);

      req = 8'h02;
      cyc(1);
      chk("t5_grant", int'(ifa.grant_o), 'h02);
      req = 8'h00;
      cyc(1);
      chk("t5_drop", int'(ifa.grant_o), 0);
      chk("t5_drop_valid", int'(ifa.grant_valid_o), 0);
      chk("t5_drop_tmo", int'(ifa.timeout_o), 0);

      req = 8'h10;
      cyc(1);
      chk("t6_grant", int'(ifa.grant_o), 'h10);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("t6_rst", int'(ifa.grant_o), 0);
      req = 8'h11;
      cyc(1);
      chk("t6_ptr", int'(ifa.grant_o), 'h01);

      for (int n = 0; n < 400; n++) begin
         req  = 8'($urandom) & 8'($urandom);
         done = ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 60) == 0);
         cyc(1);
      end
      rst = 1'b0; req = 8'h00; done = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
